// File: rtl/thread_scheduler_pkg.sv
// Shared types and helpers for the barrel thread scheduler.
// No logic of its own; constants and the per-thread base PC helper.
// No flow control.
package thread_scheduler_pkg;

  localparam int TID_W       = 2;
  localparam int NUM_THREADS = 4;

  typedef logic [TID_W-1:0] tid_t;

  // FSM encoding kept as plain constants so legacy tools can read it.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Each thread owns one quarter of instruction memory.
  function automatic int unsigned thread_base(input int unsigned t, input int unsigned aw);
    return t << (aw - 2);
  endfunction

endpackage

// File: rtl/thread_pc_file.sv
// Per-thread PC register file: base load, redirect, increment (that priority).
// Write lands next cycle; read is combinational by thread id.
// No backpressure; the caller gates the increment.
module thread_pc_file
  import thread_scheduler_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_base,
  input  logic          redir_vld,
  input  tid_t          redir_thread,
  input  logic [AW-1:0] redir_pc,
  input  logic          inc_vld,
  input  tid_t          inc_thread,
  input  tid_t          rd_thread,
  output logic [AW-1:0] rd_pc
);

  logic [AW-1:0] base_pc [NUM_THREADS];
  logic [AW-1:0] pc_d    [NUM_THREADS];
  logic [AW-1:0] pc_q    [NUM_THREADS];

  // Next PC per thread: start load beats redirect beats increment.
  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      base_pc[i] = AW'(thread_base(i, AW));
      pc_d[i]    = pc_q[i];
      if (load_base) begin
        pc_d[i] = base_pc[i];
      end else if (redir_vld && (redir_thread == TID_W'(i))) begin
        pc_d[i] = redir_pc;
      end else if (inc_vld && (inc_thread == TID_W'(i))) begin
        pc_d[i] = pc_q[i] + AW'(1);
      end
    end
  end

  // PC registers; reset parks every thread at its own base.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (rst) pc_q[i] <= base_pc[i];
      else     pc_q[i] <= pc_d[i];
    end
  end

  assign rd_pc = pc_q[rd_thread];

endmodule

// File: rtl/thread_scheduler.sv
// Barrel scheduler: one fetch slot per cycle in strict 4-thread rotation.
// Fetch outputs are combinational from registered slot/PC state (0 cycles).
// stall_i freezes rotation and PC advance; redirect/halt still land.
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int INSTMEM_LOG2_DEEP = 8,
  parameter int PIPE_DEPTH        = 5
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start_i,
  input  logic [NUM_THREADS-1:0]       thread_en_i,
  input  logic                         stall_i,
  input  logic                         redirect_valid_i,
  input  logic [TID_W-1:0]             redirect_thread_i,
  input  logic [INSTMEM_LOG2_DEEP-1:0] redirect_pc_i,
  input  logic                         halt_valid_i,
  input  logic [TID_W-1:0]             halt_thread_i,
  output logic                         fetch_valid_o,
  output logic [TID_W-1:0]             fetch_thread_o,
  output logic [INSTMEM_LOG2_DEEP-1:0] fetch_pc_o,
  output logic [NUM_THREADS-1:0]       active_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam logic [7:0] DRAIN_LAST = 8'(PIPE_DEPTH - 1);

  state_t                 state_q, state_d;
  tid_t                   slot_q, slot_d;
  logic [NUM_THREADS-1:0] active_q, active_d;
  logic [7:0]             drain_cnt_q, drain_cnt_d;
  logic                   load_base;
  logic                   redir_en;
  logic                   drain_last;

  assign drain_last     = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
  assign fetch_valid_o  = (state_q == ST_RUN) && active_q[slot_q] && !stall_i;
  assign fetch_thread_o = slot_q;
  assign active_o       = active_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = drain_last;

  // FSM, slot rotation, active flags and drain countdown.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    active_d    = active_q;
    drain_cnt_d = drain_cnt_q;
    load_base   = 1'b0;
    redir_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          load_base   = 1'b1;
          active_d    = thread_en_i;
          slot_d      = '0;
          drain_cnt_d = '0;
          state_d     = (thread_en_i == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // Rotation ignores activity so every thread keeps a fixed 4-cycle cadence.
        if (!stall_i) slot_d = slot_q + TID_W'(1);
        redir_en = redirect_valid_i;
        if (halt_valid_i) active_d[halt_thread_i] = 1'b0;
        if (active_d == '0) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Counts wall-clock cycles; stall does not hold the drain.
        if (drain_last) state_d = ST_IDLE;
        else            drain_cnt_d = drain_cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      active_q    <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      active_q    <= active_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  thread_pc_file #(
    .AW(INSTMEM_LOG2_DEEP)
  ) u_pc_file (
    .clk         (CLK),
    .rst         (RST),
    .load_base   (load_base),
    .redir_vld   (redir_en),
    .redir_thread(redirect_thread_i),
    .redir_pc    (redirect_pc_i),
    .inc_vld     (fetch_valid_o),
    .inc_thread  (slot_q),
    .rd_thread   (slot_q),
    .rd_pc       (fetch_pc_o)
  );

endmodule
